sram_port_arbiter: RTL

- Shares one single-outstanding SRAM-style memory port between the instruction-fetch requester (InstructionMemory) and the data requester (load/store stage).
- Grants one transaction at a time and routes the response back to the owner.
- Data has priority, with a bounded-burst anti-starvation rule for fetch.
- Supports fetch-response kill on jump or exception.
- Sits between the core and the external memory/bus adapter.

---
 rtl/core_mem_pkg.sv | 14 +
 rtl/sram_port_arbiter_if.sv | 26 ++
 rtl/arb_prio_pick.sv | 11 +
 rtl/sram_port_arbiter.sv | 67 ++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types and constants for the SRAM port arbiter
package core_mem_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int BURST_W = 4;
    localparam logic [3:0] FETCH_BE = 4'hF;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic wr;
        logic [3:0] be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch, data and downstream memory signals of the arbiter
interface sram_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic inst_req, inst_kill, inst_ready, inst_valid;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic data_req, data_wr, data_ready, data_valid;
    logic [3:0] data_be;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic mem_req, mem_wr, mem_ready, mem_valid;
    logic [3:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input inst_req, inst_addr, inst_kill, data_req, data_wr, data_be, data_addr, data_wdata,
              mem_ready, mem_rdata, mem_valid,
        output inst_ready, inst_rdata, inst_valid, data_ready, data_rdata, data_valid,
               mem_req, mem_wr, mem_be, mem_addr, mem_wdata
    );
    modport master (
        output inst_req, inst_addr, inst_kill, data_req, data_wr, data_be, data_addr, data_wdata,
               mem_ready, mem_rdata, mem_valid,
        input inst_ready, inst_rdata, inst_valid, data_ready, data_rdata, data_valid,
              mem_req, mem_wr, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_prio_pick.sv
// arb_prio_pick: data-first 2-way picker; a saturated data burst yields to a pending fetch
module arb_prio_pick (
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic sat_i,
    output logic gnt_inst_o,
    output logic gnt_data_o
);
    assign gnt_data_o = data_req_i && !(inst_req_i && sat_i);
    assign gnt_inst_o = inst_req_i && !gnt_data_o;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-outstanding memory port between fetch and data,
// issuing a new request in the same cycle the previous response returns.
module sram_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DATA_BURST_MAX = 4
) (
    input logic clk,
    input logic reset,
    sram_port_arbiter_if.slave bus
);
    localparam logic [BURST_W-1:0] BMAX = BURST_W'(DATA_BURST_MAX);
    arb_state_t state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic kill_q, kill_d;
    logic slot, rsp, pick_i, pick_d, gnt_i, gnt_d, acc_i, acc_d;
    mem_req_t req;
    arb_prio_pick u_pick (
        .inst_req_i(bus.inst_req),
        .data_req_i(bus.data_req),
        .sat_i(burst_q == BMAX),
        .gnt_inst_o(pick_i),
        .gnt_data_o(pick_d)
    );
    always_comb begin
        rsp = !reset && state_q != IDLE && bus.mem_valid;
        slot = !reset && (state_q == IDLE || bus.mem_valid);
        gnt_i = slot && pick_i;
        gnt_d = slot && pick_d;
        acc_i = gnt_i && bus.mem_ready;
        acc_d = gnt_d && bus.mem_ready;
        req = gnt_i ? mem_req_t'{MEM_ADDR_W'(bus.inst_addr), 1'b0, FETCH_BE, '0}
            : gnt_d ? mem_req_t'{MEM_ADDR_W'(bus.data_addr), bus.data_wr, bus.data_be, MEM_DATA_W'(bus.data_wdata)}
            : '0;
        state_d = acc_i ? BUSY_I : acc_d ? BUSY_D : rsp ? IDLE : state_q;
        burst_d = (!bus.inst_req || acc_i) ? '0
                : (acc_d && burst_q != BMAX) ? burst_q + BURST_W'(1) : burst_q;
        // a kill in the accepting cycle belongs to the fetch just issued
        kill_d = acc_i ? bus.inst_kill
               : (rsp && state_q == BUSY_I) ? 1'b0
               : kill_q || (state_q == BUSY_I && bus.inst_kill);
    end
    assign bus.mem_req = gnt_i || gnt_d;
    assign bus.mem_wr = req.wr;
    assign bus.mem_be = req.be;
    assign bus.mem_addr = ADDR_W'(req.addr);
    assign bus.mem_wdata = DATA_W'(req.wdata);
    assign bus.inst_ready = acc_i;
    assign bus.data_ready = acc_d;
    assign bus.inst_valid = rsp && state_q == BUSY_I && !kill_q && !bus.inst_kill;
    assign bus.data_valid = rsp && state_q == BUSY_D;
    assign bus.inst_rdata = bus.mem_rdata;
    assign bus.data_rdata = bus.mem_rdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            kill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            kill_q <= kill_d;
        end
    end
endmodule
